// File: rtl/ext_feat_hist_store_pkg.sv
// Shared TFE types for the extreme-value history store: default widths,
// pipeline-stage record and the bulk-clear sequencer states.
package ext_feat_hist_store_pkg;

    localparam int DEF_FLOW_IDX_W = 8;
    localparam int DEF_DATA_W     = 8;
    // Stage records carry the index zero-extended to this width (max supported FLOW_IDX_W)
    localparam int STG_IDX_W      = 16;

    typedef struct packed {
        logic                 valid;
        logic [STG_IDX_W-1:0] flow_idx;
    } stage_t;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_DRAIN = 2'd1,
        CLR_SWEEP = 2'd2
    } clr_state_e;

endpackage

// File: rtl/ext_hist_ram.sv
// Per-flow history storage: data array (not reset) plus async-reset valid bits,
// one synchronous write port and one combinational read port.
module ext_hist_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wvalid,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] data_r [DEPTH];
    logic [DEPTH-1:0]  valid_r;

    // Data array write; contents are only meaningful where the valid bit is set
    always_ff @(posedge clk) begin
        if (we) begin
            data_r[waddr] <= wdata;
        end
    end

    // Valid bits, cleared by reset so stale data is never presented as history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (we) begin
            valid_r[waddr] <= wvalid;
        end
    end

    assign rdata  = data_r[raddr];
    assign rvalid = valid_r[raddr];

endmodule

// File: rtl/ext_feat_hist_store.sv
// Per-flow extreme-value history store feeding the max/min ALU and writing its result back.
// Optional bulk clear (i_clr_all port and sweep sequencer) is built with EXT_HIST_CLR_ALL_EN.
module ext_feat_hist_store
    import ext_feat_hist_store_pkg::*;
#(
    parameter int FLOW_IDX_W = DEF_FLOW_IDX_W,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_pkt_v,
    output logic                  o_pkt_rdy,
    input  logic [FLOW_IDX_W-1:0] i_flow_idx,
    input  logic                  i_flow_new,
    input  logic [DATA_W-1:0]     i_cur_data,
    output logic [DATA_W-1:0]     o_hist_data,
    output logic                  o_hist_data_v,
    output logic [DATA_W-1:0]     o_cur_data,
    output logic                  o_cur_data_v,
    input  logic [DATA_W-1:0]     i_extreme_data,
    input  logic                  i_extreme_data_v,
`ifdef EXT_HIST_CLR_ALL_EN
    input  logic                  i_clr_all,
`endif
    output logic                  o_wb_err
);

    stage_t                s1_r;
    stage_t                s2_r;
    logic [STG_IDX_W-1:0]  in_idx_s;
    logic                  hazard_s1_s;
    logic                  res_ok_s;
    logic                  fwd_s2_s;
    logic                  clr_block_s;
    logic                  rdy_s;
    logic                  accept_s;
    logic                  we_s;
    logic [FLOW_IDX_W-1:0] waddr_s;
    logic [DATA_W-1:0]     wdata_s;
    logic                  wvalid_s;
    logic [DATA_W-1:0]     rdata_s;
    logic                  rvalid_s;

    assign in_idx_s = STG_IDX_W'(i_flow_idx);

    // A new flow does not read history, so it never needs to wait for S1's write-back
    assign hazard_s1_s = i_pkt_v && s1_r.valid && (s1_r.flow_idx == in_idx_s) && !i_flow_new;
    assign res_ok_s    = s2_r.valid && i_extreme_data_v;
    assign fwd_s2_s    = res_ok_s && (s2_r.flow_idx == in_idx_s);
    assign rdy_s       = !hazard_s1_s && !clr_block_s;
    assign accept_s    = i_pkt_v && rdy_s;
    assign o_pkt_rdy   = rdy_s;

`ifdef EXT_HIST_CLR_ALL_EN
    clr_state_e            clr_state_r;
    logic [FLOW_IDX_W-1:0] sweep_cnt_r;

    // Ready drops in the pulse cycle itself, before the sequencer registers it
    assign clr_block_s = (clr_state_r != CLR_IDLE) || i_clr_all;

    // Bulk-clear sequencer: drain S1/S2, then sweep one entry per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state_r <= CLR_IDLE;
            sweep_cnt_r <= '0;
        end else begin
            case (clr_state_r)
                CLR_IDLE: begin
                    if (i_clr_all) begin
                        clr_state_r <= CLR_DRAIN;
                    end
                end
                CLR_DRAIN: begin
                    if (!s1_r.valid && !s2_r.valid) begin
                        clr_state_r <= CLR_SWEEP;
                        sweep_cnt_r <= '0;
                    end
                end
                CLR_SWEEP: begin
                    if (sweep_cnt_r == {FLOW_IDX_W{1'b1}}) begin
                        clr_state_r <= CLR_IDLE;
                    end else begin
                        sweep_cnt_r <= sweep_cnt_r + FLOW_IDX_W'(1);
                    end
                end
                default: begin
                    clr_state_r <= CLR_IDLE;
                    sweep_cnt_r <= '0;
                end
            endcase
        end
    end

    // Write port: sweep clears take the port; the pipeline is empty while sweeping
    always_comb begin
        we_s     = 1'b0;
        waddr_s  = '0;
        wdata_s  = '0;
        wvalid_s = 1'b0;
        if (clr_state_r == CLR_SWEEP) begin
            we_s    = 1'b1;
            waddr_s = sweep_cnt_r;
        end else if (res_ok_s) begin
            we_s     = 1'b1;
            waddr_s  = FLOW_IDX_W'(s2_r.flow_idx);
            wdata_s  = i_extreme_data;
            wvalid_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end
`else
    assign clr_block_s = 1'b0;

    // Write port: ALU result lands in the flow entry held in S2
    always_comb begin
        we_s     = 1'b0;
        waddr_s  = '0;
        wdata_s  = '0;
        wvalid_s = 1'b0;
        if (res_ok_s) begin
            we_s     = 1'b1;
            waddr_s  = FLOW_IDX_W'(s2_r.flow_idx);
            wdata_s  = i_extreme_data;
            wvalid_s = 1'b1;
        end else begin
            we_s = 1'b0;
        end
    end
`endif

    ext_hist_ram #(
        .ADDR_W (FLOW_IDX_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (we_s),
        .waddr  (waddr_s),
        .wdata  (wdata_s),
        .wvalid (wvalid_s),
        .raddr  (i_flow_idx),
        .rdata  (rdata_s),
        .rvalid (rvalid_s)
    );

    // Pipeline stage records; a result arriving with S2 empty is not written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_r <= '0;
            s2_r <= '0;
        end else begin
            s1_r.valid    <= accept_s;
            s1_r.flow_idx <= accept_s ? in_idx_s : '0;
            s2_r          <= s1_r;
        end
    end

    // ALU operand registers; the S2 result is forwarded over the not-yet-written entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_cur_data    <= '0;
            o_cur_data_v  <= 1'b0;
            o_hist_data   <= '0;
            o_hist_data_v <= 1'b0;
        end else if (accept_s) begin
            o_cur_data   <= i_cur_data;
            o_cur_data_v <= 1'b1;
            if (i_flow_new) begin
                o_hist_data   <= '0;
                o_hist_data_v <= 1'b0;
            end else if (fwd_s2_s) begin
                o_hist_data   <= i_extreme_data;
                o_hist_data_v <= 1'b1;
            end else begin
                o_hist_data   <= rdata_s;
                o_hist_data_v <= rvalid_s;
            end
        end else begin
            o_cur_data    <= '0;
            o_cur_data_v  <= 1'b0;
            o_hist_data   <= '0;
            o_hist_data_v <= 1'b0;
        end
    end

    // Sticky flag for an ALU result with no packet waiting for it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_wb_err <= 1'b0;
        end else if (i_extreme_data_v && !s2_r.valid) begin
            o_wb_err <= 1'b1;
        end else begin
            o_wb_err <= o_wb_err;
        end
    end

endmodule

// File: tb/tb_ext_feat_hist_store.sv
// Scoreboard bench for ext_feat_hist_store: the bench plays the min-ALU and keeps its own flow table.
module tb_ext_feat_hist_store;

    logic       clk;
    logic       rst_n;
    logic       i_pkt_v;
    logic       o_pkt_rdy;
    logic [7:0] i_flow_idx;
    logic       i_flow_new;
    logic [7:0] i_cur_data;
    logic [7:0] o_hist_data;
    logic       o_hist_data_v;
    logic [7:0] o_cur_data;
    logic       o_cur_data_v;
    logic [7:0] i_extreme_data;
    logic       i_extreme_data_v;
    logic       o_wb_err;
`ifdef EXT_HIST_CLR_ALL_EN
    logic       i_clr_all;
`endif

    ext_feat_hist_store dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_pkt_v          (i_pkt_v),
        .o_pkt_rdy        (o_pkt_rdy),
        .i_flow_idx       (i_flow_idx),
        .i_flow_new       (i_flow_new),
        .i_cur_data       (i_cur_data),
        .o_hist_data      (o_hist_data),
        .o_hist_data_v    (o_hist_data_v),
        .o_cur_data       (o_cur_data),
        .o_cur_data_v     (o_cur_data_v),
        .i_extreme_data   (i_extreme_data),
        .i_extreme_data_v (i_extreme_data_v),
`ifdef EXT_HIST_CLR_ALL_EN
        .i_clr_all        (i_clr_all),
`endif
        .o_wb_err         (o_wb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       v;
        logic [7:0] idx;
        logic       nw;
        logic [7:0] cur;
        logic       spur;
        logic       skip;
        logic       clr;
    } stim_t;

    typedef struct packed {
        logic       v;
        logic [7:0] idx;
        logic [7:0] hist;
        logic       hv;
        logic [7:0] cur;
        logic       skip;
    } pp_t;

    typedef struct packed {
        logic [7:0] hist;
        logic       hv;
        logic       chk_h;
        logic [7:0] cur;
    } exp_t;

    exp_t  sb[$];
    stim_t tbl[$];
    pp_t   p1;
    pp_t   p2;
    logic [7:0] m_data [256];
    logic       m_v    [256];
    logic       m_k    [256];
    logic       wb_exp;
    int         n_chk;
    int         n_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic v, input logic [7:0] idx, input logic nw,
                                 input logic [7:0] cur, input logic spur, input logic skip);
        stim_t s;
        s.v = v; s.idx = idx; s.nw = nw; s.cur = cur; s.spur = spur; s.skip = skip; s.clr = 1'b0;
        return s;
    endfunction

    // One clock cycle, entered and left at a falling edge
    task automatic do_cycle(input stim_t s, input logic chk_rdy, output logic acc);
        exp_t       e;
        pp_t        n;
        logic       exp_rdy;
        logic [7:0] res;
        if (p1.v) begin
            if (sb.size() == 0) begin
                chk("sb_empty", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("cur_v", o_cur_data_v, 1);
                chk("cur", o_cur_data, e.cur);
                chk("hist_v", o_hist_data_v, e.hv);
                if (e.chk_h) chk("hist", o_hist_data, e.hist);
            end
        end else begin
            chk("idle_cur_v", o_cur_data_v, 0);
            chk("idle_hist_v", o_hist_data_v, 0);
            chk("idle_cur", o_cur_data, 0);
            chk("idle_hist", o_hist_data, 0);
        end
        chk("wb_err", o_wb_err, wb_exp);

        res = (p2.hv && p2.hist < p2.cur) ? p2.hist : p2.cur;
        i_extreme_data_v = (p2.v && !p2.skip) || s.spur;
        i_extreme_data   = p2.v ? res : 8'hEE;
        i_pkt_v          = s.v;
        i_flow_idx       = s.idx;
        i_flow_new       = s.nw;
        i_cur_data       = s.cur;
`ifdef EXT_HIST_CLR_ALL_EN
        i_clr_all        = s.clr;
`endif
        exp_rdy = !(s.v && p1.v && p1.idx == s.idx && !s.nw) && !s.clr;
        #1;
        if (chk_rdy) chk("rdy", o_pkt_rdy, exp_rdy);
        acc = s.v && exp_rdy;

        n = '0;
        if (acc) begin
            n.v = 1'b1; n.idx = s.idx; n.cur = s.cur; n.skip = s.skip;
            if (s.nw) begin
                n.hist = 8'h00; n.hv = 1'b0; e.chk_h = 1'b1;
            end else if (p2.v && !p2.skip && p2.idx == s.idx) begin
                n.hist = res; n.hv = 1'b1; e.chk_h = 1'b1;
            end else begin
                n.hist = m_data[s.idx]; n.hv = m_v[s.idx]; e.chk_h = m_v[s.idx] | m_k[s.idx];
            end
            e.hist = n.hist; e.hv = n.hv; e.cur = s.cur;
            sb.push_back(e);
        end

        @(posedge clk);
        if (p2.v && !p2.skip) begin
            m_data[p2.idx] = res; m_v[p2.idx] = 1'b1; m_k[p2.idx] = 1'b1;
        end
        if (s.spur && !p2.v) wb_exp = 1'b1;
        p2 = p1;
        p1 = n;
        @(negedge clk);
    endtask

    task automatic run_tbl();
        int   i;
        int   guard;
        logic acc;
        i = 0;
        guard = 0;
        while (i < tbl.size() && guard < 1000) begin
            do_cycle(tbl[i], 1'b1, acc);
            if (!tbl[i].v || acc) i++;
            guard++;
        end
        chk("stim_guard", i, tbl.size());
        tbl.delete();
    endtask

    initial begin
        logic acc;
        int   lowcnt;
        stim_t s;
        n_chk = 0; n_err = 0; wb_exp = 1'b0;
        p1 = '0; p2 = '0;
        for (int k = 0; k < 256; k++) begin
            m_data[k] = 8'h00; m_v[k] = 1'b0; m_k[k] = 1'b0;
        end
        rst_n = 1'b0; i_pkt_v = 1'b0; i_flow_idx = 8'h00; i_flow_new = 1'b0;
        i_cur_data = 8'h00; i_extreme_data = 8'h00; i_extreme_data_v = 1'b0;
`ifdef EXT_HIST_CLR_ALL_EN
        i_clr_all = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", o_pkt_rdy, 1);
        chk("rst_cur_v", o_cur_data_v, 0);
        chk("rst_hist_v", o_hist_data_v, 0);
        chk("rst_cur", o_cur_data, 0);
        chk("rst_hist", o_hist_data, 0);
        chk("rst_wb_err", o_wb_err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // new flow, steady state, back-to-back stall, interleave, spurious, dropped result
        tbl.push_back(mk(1, 8'd5, 1, 8'h40, 0, 0));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'd5, 0, 8'h10, 0, 0));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'd7, 1, 8'h22, 0, 0));
        tbl.push_back(mk(1, 8'd7, 0, 8'h30, 0, 0));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'd1, 1, 8'h50, 0, 0));
        tbl.push_back(mk(1, 8'd2, 1, 8'h60, 0, 0));
        tbl.push_back(mk(1, 8'd1, 0, 8'h20, 0, 0));
        tbl.push_back(mk(1, 8'd2, 0, 8'h70, 0, 0));
        tbl.push_back(mk(1, 8'd1, 0, 8'h30, 0, 0));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'd5, 0, 8'h80, 0, 0));
        tbl.push_back(mk(1, 8'd9, 1, 8'h11, 0, 1));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 8'd9, 0, 8'h05, 0, 0));
        tbl.push_back(mk(1, 8'd5, 0, 8'h03, 0, 0));
        tbl.push_back(mk(1, 8'd7, 0, 8'hF0, 0, 0));
        for (int r = 0; r < 60; r++) begin
            tbl.push_back(mk(($urandom_range(0, 4) != 0), 8'($urandom_range(0, 3)),
                             ($urandom_range(0, 3) == 0), 8'($urandom_range(0, 255)), 0, 0));
        end
        for (int r = 0; r < 3; r++) tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        run_tbl();

`ifdef EXT_HIST_CLR_ALL_EN
        // bulk clear with a packet in flight, then a flow-5 packet must see no history
        do_cycle(mk(1, 8'd5, 0, 8'h33, 0, 0), 1'b1, acc);
        s = mk(0, 8'd0, 0, 8'h00, 0, 0);
        s.clr = 1'b1;
        do_cycle(s, 1'b1, acc);
        lowcnt = 1;
        while (o_pkt_rdy !== 1'b1 && lowcnt < 400) begin
            do_cycle(mk(0, 8'd0, 0, 8'h00, 0, 0), 1'b0, acc);
            lowcnt++;
        end
        chk("clr_rdy_back", o_pkt_rdy, 1);
        chk("clr_low_min", (lowcnt >= 256), 1);
        chk("clr_low_max", (lowcnt <= 264), 1);
        for (int k = 0; k < 256; k++) begin
            m_data[k] = 8'h00; m_v[k] = 1'b0; m_k[k] = 1'b1;
        end
        tbl.push_back(mk(1, 8'd5, 0, 8'h44, 0, 0));
        tbl.push_back(mk(1, 8'd1, 0, 8'h45, 0, 0));
        for (int r = 0; r < 3; r++) tbl.push_back(mk(0, 8'd0, 0, 8'h00, 0, 0));
        run_tbl();
`else
        s = '0;
        lowcnt = 0;
        acc = 1'b0;
`endif

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ext_feat_hist_store.md
Name: ext_feat_hist_store

Overview:
- Per-flow history store feeding the max/min extreme-value ALU; it is the producer of that ALU's hist/cur operands and the consumer of its result.
- For each packet it reads the flow's stored extreme value, presents hist/cur operands aligned to the ALU, and writes the ALU result back to the same flow entry.
- Sits in the TFE between the flow-index lookup and the feature ALU bank. One instance per extreme-value feature.

Parameters:
- FLOW_IDX_W, 8, flow index width; table depth = 2**FLOW_IDX_W entries.
- DATA_W, 8, feature data width; must match the ALU operand width.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- i_pkt_v  in  1  packet feature valid
- o_pkt_rdy  out  1  block accepts packet this cycle (i_pkt_v & o_pkt_rdy = accept)
- i_flow_idx  in  FLOW_IDX_W  flow table index of packet
- i_flow_new  in  1  first packet of flow; stored history is ignored
- i_cur_data  in  DATA_W  packet feature value
- o_hist_data  out  DATA_W  stored extreme value to ALU
- o_hist_data_v  out  1  stored value valid
- o_cur_data  out  DATA_W  packet value to ALU
- o_cur_data_v  out  1  operand pair valid
- i_extreme_data  in  DATA_W  ALU result
- i_extreme_data_v  in  1  ALU result valid
- o_wb_err  out  1  sticky: result arrived with no write-back pending

Behaviour:
- Reset (async, rst_n low): all outputs 0 except o_pkt_rdy = 1; all entry valid bits 0; pipeline emptied. Data array is not reset. Reset mid-operation discards in-flight packets; no write-back occurs.
- Storage: DATA_W data plus 1 valid bit per entry; one write port; combinational read of the valid bit and data.
- S0 (accept, cycle T): the packet is accepted. Registered operands are loaded at the T edge:
  - o_cur_data = i_cur_data; o_cur_data_v = 1.
  - o_hist_data / o_hist_data_v = entry data / valid bit.
  - If i_flow_new = 1: o_hist_data = 0 and o_hist_data_v = 0.
- S1 (T+1): the operands are visible to the ALU. The flow index moves to the S2 register.
- S2 (T+2): i_extreme_data_v is required to be high this cycle. At the T+2 edge, entry[S2 idx] is written with data = i_extreme_data and valid = 1.
- Idle: with no accept, o_cur_data_v = 0, o_hist_data_v = 0, and both data outputs = 0.
- Throughput: one packet per cycle when flow indices differ.
- Hazard with S1:
  - Condition: i_pkt_v high and i_flow_idx equals the S1 index with S1 valid.
  - Response: o_pkt_rdy = 0 for that cycle (one-cycle stall).
  - Exception: no stall when i_flow_new = 1, since history is not needed.
- Hazard with S2:
  - Condition: accepted packet's i_flow_idx equals the S2 index with i_extreme_data_v high.
  - Response: o_hist_data = i_extreme_data and o_hist_data_v = 1 (forwarded, not the stale entry).
- Write-back with no packet pending (S2 empty and i_extreme_data_v = 1): no write; o_wb_err is set and held until reset.
- Missing ALU result: S2 valid but i_extreme_data_v = 0 means the packet is dropped; the entry is left unchanged.
- Index wrap: none; the index addresses directly and all values are legal.

Optional Feature:
- Macro: EXT_HIST_CLR_ALL_EN.
- Without the macro: there is no bulk clear, and no i_clr_all port exists.
- With the macro:
  - Adds input i_clr_all (1-bit pulse).
  - On the pulse, o_pkt_rdy drops at once. The block waits until S1 and S2 are empty, then runs a sweep counter 0 .. 2**FLOW_IDX_W-1, writing valid = 0 and data = 0 to one entry per cycle.
  - o_pkt_rdy returns to 1 the cycle after the last entry is written.
  - i_clr_all during a sweep is ignored. Reset aborts the sweep; the async clear covers it.

Decomposition:
- Shared TFE package: DATA_W and FLOW_IDX_W defaults, and a pipeline-stage struct {valid, flow_idx}.
- One natural sub-module, ext_hist_ram: the storage array with async-reset valid bits, one write port, one combinational read port.
- Hazard, forwarding and the sweep FSM stay in the top-level block.

Test Plan:
- New flow: reset, accept flow 5 with new = 1, cur = 0x40 → T+1 shows hist_v = 0, cur = 0x40. ALU returns 0x40 at T+2 → entry 5 = 0x40, valid = 1.
- Steady state: flow 5 holds 0x40; accept cur = 0x10 → T+1 shows hist = 0x40, hist_v = 1. ALU min returns 0x10 → entry 5 = 0x10.
- Back-to-back stall: flow 7 accepted at T, second flow-7 packet at T+1 → o_pkt_rdy = 0 at T+1. Re-accepted at T+2 with hist forwarded from i_extreme_data.
- Interleave: flows 1, 2, 1, 2 on consecutive cycles → no stalls. Each flow-1/flow-2 second packet gets its forwarded S2 result.
- Spurious result: i_extreme_data_v = 1 with the pipeline empty → o_wb_err = 1 and stays 1; no entry changes.
- With EXT_HIST_CLR_ALL_EN, FLOW_IDX_W = 3: i_clr_all while a packet is in flight → the packet drains, then 8 sweep cycles run. o_pkt_rdy returns, and the next flow-5 packet shows hist_v = 0.
